// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, header field layout and the release-delay counter width.
package mips_boot_pkg;

  // Loader FSM states; ST_CHECK is only reachable when the checksum
  // word is part of the stream.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_e;

  // Stream words are 32 bits wide.
  localparam int WORD_W = 32;

  // The word count sits in the low bits of the header word.
  localparam int HDR_CNT_LSB = 0;

  // The count field is one bit wider than the address so that a full
  // memory (2**addr_w words) can be requested.
  function automatic int hdr_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Release-delay counter width; covers hold lengths up to 15 cycles.
  localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Valid/ready word stream feeding the boot loader. The master side is the
// program source, the slave side is the loader.
interface imem_boot_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_boot_loader_checksum.sv
// Running 32-bit sum of loaded instruction words (wraps modulo 2^32).
module boot_checksum_acc (
  input  logic        clk,
  input  logic        clear,
  input  logic        add_en,
  input  logic [31:0] data,
  output logic [31:0] sum
);

  // Clear has priority so a new header always starts from zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program (header word N, then N instruction words) into
// instruction memory while holding the core in reset, then releases the
// core so it fetches from PC 0.
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to require a trailing
// checksum word equal to the 32-bit sum of the instruction words.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_start,
  imem_boot_loader_if.slave     up,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

  localparam int HDR_CNT_W = hdr_cnt_w(ADDR_WIDTH);
  localparam logic [HDR_CNT_W-1:0] DEPTH = HDR_CNT_W'(1) << ADDR_WIDTH;

  boot_state_e            state;
  logic [ADDR_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0]  last_idx;
  logic [HOLD_CNT_W-1:0]  hold_cnt;

  logic                   xfer;
  logic [HDR_CNT_W-1:0]   hdr_n;
  logic                   hdr_bad;

  assign xfer  = up.in_valid && up.in_ready;
  assign hdr_n = up.in_data[HDR_CNT_LSB +: HDR_CNT_W];
  // Reject empty programs, programs larger than the memory, and headers
  // with stray bits above the count field.
  assign hdr_bad = (hdr_n == '0) || (hdr_n > DEPTH) ||
                   (up.in_data[WORD_W-1:HDR_CNT_W] != '0);

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] acc_sum;

  boot_checksum_acc u_acc (
    .clk    (clk),
    .clear  (rst || (state == ST_HEADER && xfer)),
    .add_en (state == ST_LOAD && xfer),
    .data   (up.in_data),
    .sum    (acc_sum)
  );
`endif

  // Loader FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      up.in_ready <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      cnt         <= '0;
      last_idx    <= '0;
      hold_cnt    <= '0;
    end else begin
      // Write strobe is a single-cycle pulse following each LOAD transfer.
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (boot_start) begin
            state       <= ST_HEADER;
            up.in_ready <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (xfer) begin
            if (hdr_bad) begin
              state       <= ST_ERROR;
              up.in_ready <= 1'b0;
              error       <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              cnt      <= '0;
              // For a full-depth load the low bits of N are zero, so this
              // still yields the top address.
              last_idx <= hdr_n[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt;
            mem_wdata <= up.in_data;
            cnt       <= cnt + ADDR_WIDTH'(1);
            if (cnt == last_idx) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state       <= ST_HOLD;
              up.in_ready <= 1'b0;
              hold_cnt    <= '0;
`endif
            end
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            up.in_ready <= 1'b0;
            if (up.in_data == acc_sum) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        ST_HOLD: begin
          // The first HOLD cycle coincides with the final write strobe, so
          // counting to RST_HOLD leaves RST_HOLD cycles of reset after it.
          if (hold_cnt == HOLD_CNT_W'(RST_HOLD)) begin
            state    <= ST_RUN;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (boot_start) begin
            state       <= ST_HEADER;
            up.in_ready <= 1'b1;
            core_rst    <= 1'b1;
            done        <= 1'b0;
          end
        end
        ST_ERROR: begin
          // Sticky until rst.
        end
        default: begin
          state       <= ST_IDLE;
          up.in_ready <= 1'b0;
          core_rst    <= 1'b1;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: programs are generated with
// $urandom, streamed with optional idle gaps, and the resulting memory
// image, write order and core release timing are compared with what the
// stream itself implies.
module tb_imem_boot_loader;

  localparam int AW    = 8;
  localparam int RH    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          boot_start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  imem_boot_loader_if bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .RST_HOLD(RH)) dut (
    .clk        (clk),
    .rst        (rst),
    .boot_start (boot_start),
    .up         (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Instruction memory seen by the core, plus a log of every write.
  logic [31:0] tb_mem [DEPTH];
  int          wr_cnt = 0;
  int          wr_addr_q[$];
  int          wr_cyc_q[$];
  int          last_wr_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (mem_we) begin
      tb_mem[mem_addr] = mem_wdata;
      wr_cnt++;
      wr_addr_q.push_back(int'(mem_addr));
      wr_cyc_q.push_back(cyc);
      last_wr_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    boot_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'hDEAD_BEEF;
  endtask

  // Offers one word and waits (bounded) until it is accepted. With gaps,
  // random idle cycles carry junk data and stray boot_start pulses first.
  task automatic push_word(input logic [31:0] w, input bit gaps);
    bit ok;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        boot_start   = ($urandom_range(0, 3) == 0);
        tick();
      end
      boot_start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = bus.in_ready;
      tick();
    end
    if (!ok) check_val("accept_timeout", 0, 1);
  endtask

  task automatic load_program(input logic [31:0] prog[$], input bit gaps);
    logic [31:0] sum;
    sum = '0;
    push_word(32'(prog.size()), gaps);
    foreach (prog[i]) begin
      push_word(prog[i], gaps);
      sum = sum + prog[i];
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    push_word(sum, gaps);
`endif
    bus.in_valid = 1'b0;
  endtask

  // Waits for release and compares the memory image and write log with
  // the program; base is the write count before the load began.
  task automatic verify_run(input string tag, input logic [31:0] prog[$], input int base);
    for (int i = 0; i < 100 && !done; i++) tick();
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_core_rst"}, core_rst, 0);
    check_val({tag, "_error"}, error, 0);
    check_val({tag, "_ready"}, bus.in_ready, 0);
    check_val({tag, "_wr_cnt"}, wr_cnt - base, prog.size());
`ifndef IMEM_BOOT_CHECKSUM_EN
    check_val({tag, "_hold_len"}, cyc - last_wr_cyc, RH);
`endif
    foreach (prog[i]) begin
      check_val({tag, "_mem"}, tb_mem[i], prog[i]);
      if (base + i < wr_addr_q.size())
        check_val({tag, "_order"}, wr_addr_q[base + i], i);
    end
  endtask

  task automatic error_case(input string tag, input logic [31:0] hdr);
    int base;
    do_reset();
    base = wr_cnt;
    pulse_start();
    push_word(hdr, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check_val({tag, "_error"}, error, 1);
    check_val({tag, "_core_rst"}, core_rst, 1);
    check_val({tag, "_ready"}, bus.in_ready, 0);
    pulse_start();
    repeat (3) tick();
    check_val({tag, "_sticky"}, error, 1);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_no_we"}, wr_cnt - base, 0);
    do_reset();
    check_val({tag, "_cleared"}, error, 0);
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] prog2[$];
    int base;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clear_mem();

    // Reset state.
    do_reset();
    check_val("rst_ready", bus.in_ready, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_core_rst", core_rst, 1);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);

    // Fixed three-word program, valid held high: consecutive writes.
    prog = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020};
    base = wr_cnt;
    pulse_start();
    load_program(prog, 1'b0);
    verify_run("fixed", prog, base);
    for (int i = 1; i < 3; i++)
      check_val("fixed_b2b", wr_cyc_q[base + i] - wr_cyc_q[base + i - 1], 1);

    // Same program with idle gaps and stray boot_start pulses.
    do_reset();
    clear_mem();
    base = wr_cnt;
    pulse_start();
    load_program(prog, 1'b1);
    verify_run("gaps", prog, base);

    // Random programs, random gaps.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      do_reset();
      clear_mem();
      base = wr_cnt;
      pulse_start();
      load_program(prog, bit'($urandom_range(0, 1)));
      verify_run("rand", prog, base);
    end

    // Full-depth load reaches the top address.
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    do_reset();
    clear_mem();
    base = wr_cnt;
    pulse_start();
    load_program(prog, 1'b1);
    verify_run("full", prog, base);

    // Rejected headers.
    error_case("hdr0", 32'd0);
    error_case("hdr257", 32'd257);
    error_case("hdr_hi", 32'h0001_0003);

    // Reset after the second of three words.
    do_reset();
    base = wr_cnt;
    pulse_start();
    push_word(32'd3, 1'b0);
    push_word(32'h1111_1111, 1'b0);
    push_word(32'h2222_2222, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_ready", bus.in_ready, 0);
    check_val("mid_core_rst", core_rst, 1);
    check_val("mid_done", done, 0);
    check_val("mid_wr_cnt", wr_cnt - base, 2);
    bus.in_data = 32'h3333_3333;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    check_val("mid_no_more_we", wr_cnt - base, 2);
    prog = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    clear_mem();
    base = wr_cnt;
    pulse_start();
    load_program(prog, 1'b1);
    verify_run("mid_reload", prog, base);

    // Restart from RUN.
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    check_val("restart_core_rst", core_rst, 1);
    check_val("restart_done", done, 0);
    check_val("restart_ready", bus.in_ready, 1);
    prog2 = '{32'h0000_0020, 32'h1234_5678};
    clear_mem();
    base = wr_cnt;
    load_program(prog2, 1'b0);
    verify_run("restart", prog2, base);

    // rst and boot_start together: rst wins, loader stays idle.
    rst = 1'b1;
    boot_start = 1'b1;
    tick();
    rst = 1'b0;
    boot_start = 1'b0;
    check_val("both_ready", bus.in_ready, 0);
    check_val("both_done", done, 0);
    check_val("both_core_rst", core_rst, 1);
    repeat (3) tick();
    check_val("both_idle", bus.in_ready, 0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match and mismatch.
    do_reset();
    clear_mem();
    base = wr_cnt;
    pulse_start();
    push_word(32'd2, 1'b0);
    push_word(32'h1, 1'b0);
    push_word(32'h2, 1'b0);
    push_word(32'h3, 1'b0);
    bus.in_valid = 1'b0;
    prog = '{32'h1, 32'h2};
    verify_run("csum_ok", prog, base);
    do_reset();
    pulse_start();
    push_word(32'd2, 1'b0);
    push_word(32'h1, 1'b0);
    push_word(32'h2, 1'b0);
    push_word(32'h4, 1'b0);
    bus.in_valid = 1'b0;
    repeat (RH + 3) tick();
    check_val("csum_bad_error", error, 1);
    check_val("csum_bad_core_rst", core_rst, 1);
    check_val("csum_bad_done", done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of SingleCycleMIPS: streams a program into instruction memory over a valid/ready word interface, replacing file preload.
- Holds the core in reset (core_rst) while loading, then releases it so the core starts fetching at PC 0.
- Stream format: a header word (word count N), then N instruction words, optionally followed by a checksum word.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; memory depth = 2**ADDR_WIDTH words.
- RST_HOLD, 4, cycles that core_rst stays high after the last write, before release (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- boot_start  in  1  single-cycle pulse; begins a load (ignored while loading)
- in_valid  in  1  in_data holds a valid word
- in_data  in  32  header, instruction or checksum word
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ADDR_WIDTH  instruction-memory word address
- mem_wdata  out  32  instruction-memory write data
- core_rst  out  1  reset to SingleCycleMIPS (its rst input)
- done  out  1  program loaded and core released
- error  out  1  sticky load failure

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, error=0, word counter=0, checksum accumulator=0.
- Handshake: a transfer occurs on a rising edge when in_valid&&in_ready; in_ready is registered and depends only on state; in_data must be ignored when in_valid=0.
- FSM states: IDLE, HEADER, LOAD, CHECK, HOLD, RUN, ERROR.
- IDLE: core_rst=1; boot_start -> HEADER.
- HEADER: in_ready=1; N=in_data[ADDR_WIDTH:0]. If N==0, N>2**ADDR_WIDTH, or in_data[31:ADDR_WIDTH+1]!=0 -> ERROR; otherwise clear the counter and accumulator and go to LOAD.
- LOAD: in_ready=1. Each transfer registers mem_we=1, mem_addr=counter, mem_wdata=in_data on the next cycle (write latency 1). Counter increments and the word is added to the accumulator (mod 2^32). Throughput is 1 word/cycle. After word N-1: -> CHECK if CHECKSUM_EN, else HOLD.
- No wrap-around: the N bound ensures the address never exceeds 2**ADDR_WIDTH-1. An N equal to full depth must write the last address correctly.
- HOLD: in_ready=0; core_rst=1 for exactly RST_HOLD cycles, counted from the cycle after the last mem_we pulse; then -> RUN.
- RUN: core_rst=0, done=1, in_ready=0.
- boot_start in RUN: restarts the load. core_rst=1 and done=0 on the next cycle, then -> HEADER.
- boot_start in HEADER, LOAD, CHECK or HOLD: ignored.
- ERROR: core_rst=1, error=1, in_ready=0. Only rst clears it; boot_start is ignored.
- rst mid-load: all state is cleared on the next edge. Words already written stay in memory; no further writes occur.
- Simultaneous rst and boot_start: rst wins.
- mem_we is never asserted outside the cycle after a LOAD transfer.

Optional Feature:
- Macro IMEM_BOOT_CHECKSUM_EN.
- Defined: the CHECK state exists with in_ready=1, accepting one word. If it equals the accumulator -> HOLD; otherwise -> ERROR, and the core stays in reset.
- Undefined: no CHECK state and no accumulator logic; LOAD goes directly to HOLD.

Decomposition:
- Package mips_boot_pkg holds:
  - the state enum;
  - header field width/position constants;
  - the RST_HOLD counter width.
- One sub-module is natural: boot_checksum_acc (clear, add-enable, 32-bit data, 32-bit sum), instantiated only under IMEM_BOOT_CHECKSUM_EN.

Test Plan:
- Reset, then stream header 3 and words 0x20080005, 0x2009000A, 0x01095020 with in_valid held high -> writes to addrs 0,1,2 on three consecutive cycles. core_rst falls exactly RST_HOLD=4 cycles after the last write; done=1.
- Same program with in_valid toggling 1,0,1,0 -> identical memory contents; mem_we pulses only after accepted words.
- Header 0, then separately header 257 with ADDR_WIDTH=8 -> error=1, no mem_we, core_rst stays 1. boot_start has no effect; rst clears the error.
- With IMEM_BOOT_CHECKSUM_EN: header 2, words 0x1, 0x2, checksum 0x3 -> done=1. Repeat with checksum 0x4 -> error=1, core_rst=1.
- Assert rst after word 1 of 3 -> next cycle IDLE, in_ready=0, no further writes. A new boot_start and full stream then succeeds.
- In RUN, pulse boot_start -> core_rst=1 and done=0 the next cycle. Reload 2 words -> core released again, running the new program from PC 0.
